// File: rtl/i2s_tx_stream.sv
// Stereo I2S master transmitter: takes {left, right} pairs from a valid/ready
// stream through a one-entry holding buffer and serialises them on
// BCLK/LRCLK/SD derived from clk_i. Supports I2S and left-justified framing,
// counts underruns, and stops only on frame boundaries.
`timescale 1ns/1ps
module i2s_tx_stream #(
  parameter int DATA_W    = 24,
  parameter int SLOT_W    = 32,
  parameter int BCLK_HALF = 7,
  parameter int CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              fmt_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_left_i,
  input  logic [DATA_W-1:0] s_right_i,
  output logic              audio_bclk_o,
  output logic              audio_lrclk_o,
  output logic              audio_data_o,
  output logic              frame_start_o,
  output logic              underrun_o,
  output logic [CNT_W-1:0]  underrun_cnt_o
);

  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam int DIV_W = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT_POS = BIT_W'(SLOT_W);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [BIT_W-1:0]  pos_d;
  logic              bclk_q, bclk_d;
  logic              lrclk_q, lrclk_d;
  logic              sd_q, sd_d;
  logic              fmt_q, fmt_d;
  logic              fs_q, fs_d;
  logic              ur_q, ur_d;
  logic [CNT_W-1:0]  ur_cnt_q, ur_cnt_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic [DATA_W-1:0] hold_r_q, hold_r_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic              accept;
  logic              load;

  // Bit of sample s that goes on the wire at slot position p.
  // I2S delays the MSB by one BCLK; left-justified puts it at position 0.
  function automatic logic serial_bit(input logic [DATA_W-1:0] s,
                                      input logic [BIT_W-1:0]  p,
                                      input logic              lj);
    logic b;
    b = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (lj) begin
        if (p == BIT_W'(DATA_W - 1 - i)) b = s[i];
      end else begin
        if (p == BIT_W'(DATA_W - i)) b = s[i];
      end
    end
    return b;
  endfunction

  assign accept = s_valid_i && !hold_full_q;

  // Next-state logic: divider, bit counter, frame loads, buffer and serial bit.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    bclk_d      = bclk_q;
    fmt_d       = fmt_q;
    fs_d        = 1'b0;
    ur_d        = 1'b0;
    ur_cnt_d    = ur_cnt_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    left_d      = left_q;
    right_d     = right_q;
    load        = 1'b0;
    lrclk_d     = 1'b0;
    pos_d       = '0;
    sd_d        = 1'b0;

    case (state_q)
      IDLE: begin
        div_d  = '0;
        bit_d  = '0;
        bclk_d = 1'b0;
        if (enable_i) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          bclk_d = !bclk_q;
          if (bclk_q) begin
            // Falling BCLK edge: advance, and decide at the frame boundary.
            if (bit_q == BIT_LAST) begin
              bit_d = '0;
              if (enable_i) load = 1'b1;
              else          state_d = IDLE;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      fmt_d       = fmt_i;
      fs_d        = 1'b1;
      hold_full_d = 1'b0;
      if (hold_full_q) begin
        left_d  = hold_l_q;
        right_d = hold_r_q;
      end else begin
        left_d  = '0;
        right_d = '0;
        ur_d    = 1'b1;
        if (ur_cnt_q != '1) ur_cnt_d = ur_cnt_q + CNT_W'(1);
      end
    end

    // A load with an empty buffer has already counted the underrun above;
    // the pair accepted on that same edge waits for the following frame.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = s_left_i;
      hold_r_d    = s_right_i;
    end

    if (state_d == RUN) begin
      lrclk_d = (bit_d >= SLOT_POS);
      pos_d   = lrclk_d ? (bit_d - SLOT_POS) : bit_d;
      sd_d    = serial_bit(lrclk_d ? right_d : left_d, pos_d, fmt_d);
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      sd_q        <= 1'b0;
      fmt_q       <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
      ur_cnt_q    <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      sd_q        <= sd_d;
      fmt_q       <= fmt_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
      ur_cnt_q    <= ur_cnt_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Sample data registers.
  always_ff @(posedge clk_i) begin
    // NOTE: data registers carry no reset; hold_full qualifies the buffer and
    // every frame load rewrites the shift registers before they are used.
    hold_l_q <= hold_l_d;
    hold_r_q <= hold_r_d;
    left_q   <= left_d;
    right_q  <= right_d;
  end

  assign s_ready_o      = !hold_full_q;
  assign audio_bclk_o   = bclk_q;
  assign audio_lrclk_o  = lrclk_q;
  assign audio_data_o   = sd_q;
  assign frame_start_o  = fs_q;
  assign underrun_o     = ur_q;
  assign underrun_cnt_o = ur_cnt_q;

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Self-checking bench for i2s_tx_stream at default parameters: directed and
// random frame vectors, underrun, frame timing, stop and mid-frame reset.
`timescale 1ns/1ps
module tb_i2s_tx_stream;

  localparam int FRAME_CYC = 896;
  localparam int HALF_CYC  = 448;
  localparam int NVEC      = 24;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        fmt_i = 1'b0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [23:0] s_left_i = '0;
  logic [23:0] s_right_i = '0;
  logic        audio_bclk_o;
  logic        audio_lrclk_o;
  logic        audio_data_o;
  logic        frame_start_o;
  logic        underrun_o;
  logic [15:0] underrun_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  i2s_tx_stream dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .fmt_i          (fmt_i),
    .s_valid_i      (s_valid_i),
    .s_ready_o      (s_ready_o),
    .s_left_i       (s_left_i),
    .s_right_i      (s_right_i),
    .audio_bclk_o   (audio_bclk_o),
    .audio_lrclk_o  (audio_lrclk_o),
    .audio_data_o   (audio_data_o),
    .frame_start_o  (frame_start_o),
    .underrun_o     (underrun_o),
    .underrun_cnt_o (underrun_cnt_o)
  );

  // 40 MHz system clock
  always #12.5 clk_i = !clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        fmt;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference slot image, position 0 in bit 31.
  function automatic logic [31:0] exp_slot(input logic [23:0] s, input logic fmt);
    return fmt ? {s, 8'h00} : {1'b0, s, 7'h00};
  endfunction

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    int g;
    g = 0;
    while (!s_ready_o && g < 2000) begin
      @(negedge clk_i);
      g++;
    end
    if (!s_ready_o) begin
      timeout("push_ready");
    end else begin
      s_valid_i = 1'b1;
      s_left_i  = l;
      s_right_i = r;
      @(negedge clk_i);
      s_valid_i = 1'b0;
    end
  endtask

  task automatic wait_frame_start(output int t);
    int g;
    g = 0;
    @(negedge clk_i);
    while (!frame_start_o && g < 2000) begin
      @(negedge clk_i);
      g++;
    end
    t = cyc;
    if (!frame_start_o) timeout("frame_start");
  endtask

  task automatic wait_lrclk(input logic level, output int t);
    int g;
    g = 0;
    while (audio_lrclk_o !== level && g < 2000) begin
      @(negedge clk_i);
      g++;
    end
    t = cyc;
    if (audio_lrclk_o !== level) timeout("lrclk_edge");
  endtask

  // Samples SD and LRCLK at each of the 64 rising BCLK edges of the frame just
  // loaded, and checks the edges fall at 7 + 14*k cycles after the load.
  task automatic capture_frame(input int t0, output logic [31:0] lw, output logic [31:0] rw,
                               output logic [63:0] lrw, output logic timing_ok);
    int   n;
    int   g;
    logic prev;
    n = 0;
    g = 0;
    lw = '0;
    rw = '0;
    lrw = '0;
    timing_ok = 1'b1;
    prev = audio_bclk_o;
    while (n < 64 && g < 2000) begin
      @(negedge clk_i);
      g++;
      if (audio_bclk_o && !prev) begin
        if (cyc - t0 != 7 + 14 * n) timing_ok = 1'b0;
        if (n < 32) lw = {lw[30:0], audio_data_o};
        else        rw = {rw[30:0], audio_data_o};
        lrw = {lrw[62:0], audio_lrclk_o};
        n++;
      end
      prev = audio_bclk_o;
    end
    if (n < 64) timing_ok = 1'b0;
  endtask

  initial begin
    logic [31:0] lw, rw;
    logic [63:0] lrw;
    logic        tok;
    logic        bad;
    logic        lr895, bclk895;
    int          t0, t_prev, ta, tb, tc, td, te, fs_hz;

    // Directed vectors, slot images worked out by hand.
    vecs[0] = '{24'h9A5AC3, 24'h5A5AC2, 1'b0, 32'h4D2D6180, 32'h2D2D6100};
    vecs[1] = '{24'h9A5AC3, 24'h5A5AC2, 1'b1, 32'h9A5AC300, 32'h5A5AC200};
    vecs[2] = '{24'h800001, 24'h7FFFFE, 1'b0, 32'h40000080, 32'h3FFFFF00};
    vecs[3] = '{24'hFFFFFF, 24'h000001, 1'b1, 32'hFFFFFF00, 32'h00000100};
    for (int i = 4; i < NVEC; i++) begin
      vecs[i].l     = 24'($urandom);
      vecs[i].r     = 24'($urandom);
      vecs[i].fmt   = 1'($urandom_range(0, 1));
      vecs[i].exp_l = exp_slot(vecs[i].l, vecs[i].fmt);
      vecs[i].exp_r = exp_slot(vecs[i].r, vecs[i].fmt);
    end

    // Reset and idle
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (audio_bclk_o !== 1'b0 || audio_lrclk_o !== 1'b0 || audio_data_o !== 1'b0 ||
          frame_start_o !== 1'b0 || underrun_o !== 1'b0 || s_ready_o !== 1'b1) bad = 1'b1;
    end
    check("reset_outputs", {63'b0, bad}, 64'd0);
    check("reset_underrun_cnt", {48'b0, underrun_cnt_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_outputs", {61'b0, audio_bclk_o, audio_lrclk_o, audio_data_o}, 64'd0);

    // Vector frames: each pair is pushed during the previous frame.
    t_prev = 0;
    for (int i = 0; i < NVEC; i++) begin
      fmt_i = vecs[i].fmt;
      push(vecs[i].l, vecs[i].r);
      check($sformatf("ready_low_after_push_%0d", i), {63'b0, s_ready_o}, 64'd0);
      if (i == 0) enable_i = 1'b1;
      wait_frame_start(t0);
      check($sformatf("no_underrun_%0d", i), {63'b0, underrun_o}, 64'd0);
      check($sformatf("ready_after_load_%0d", i), {63'b0, s_ready_o}, 64'd1);
      if (i > 0) check($sformatf("frame_period_%0d", i), 64'(t0 - t_prev), 64'(FRAME_CYC));
      t_prev = t0;
      capture_frame(t0, lw, rw, lrw, tok);
      check($sformatf("left_slot_%0d", i), {32'b0, lw}, {32'b0, vecs[i].exp_l});
      check($sformatf("right_slot_%0d", i), {32'b0, rw}, {32'b0, vecs[i].exp_r});
      check($sformatf("lrclk_pattern_%0d", i), lrw, 64'h0000_0000_FFFF_FFFF);
      check($sformatf("bclk_timing_%0d", i), {63'b0, tok}, 64'd1);
    end
    check("underrun_cnt_before", {48'b0, underrun_cnt_o}, 64'd0);

    // Underrun: three frames with no sample supplied
    for (int u = 0; u < 3; u++) begin
      wait_frame_start(t0);
      check($sformatf("underrun_pulse_%0d", u), {63'b0, underrun_o}, 64'd1);
      capture_frame(t0, lw, rw, lrw, tok);
      check($sformatf("underrun_zero_data_%0d", u), {lw, rw}, 64'd0);
    end
    check("underrun_cnt_3", {48'b0, underrun_cnt_o}, 64'd3);
    fmt_i = 1'b0;
    push(24'h9A5AC3, 24'h5A5AC2);
    wait_frame_start(t0);
    check("recover_no_underrun", {63'b0, underrun_o}, 64'd0);
    capture_frame(t0, lw, rw, lrw, tok);
    check("recover_data", {lw, rw}, {32'h4D2D6180, 32'h2D2D6100});
    check("underrun_cnt_still_3", {48'b0, underrun_cnt_o}, 64'd3);

    // LRCLK frequency and duty over two periods
    wait_lrclk(1'b0, ta);
    wait_lrclk(1'b1, tb);
    wait_lrclk(1'b0, tc);
    wait_lrclk(1'b1, td);
    wait_lrclk(1'b0, te);
    check("lrclk_low_half", 64'(tb - ta), 64'(HALF_CYC));
    check("lrclk_high_half", 64'(tc - tb), 64'(HALF_CYC));
    check("lrclk_period_1", 64'(tc - ta), 64'(FRAME_CYC));
    check("lrclk_period_2", 64'(te - tc), 64'(FRAME_CYC));
    fs_hz = 40_000_000 / (te - tc);
    check("fs_within_2khz_of_44100", {63'b0, (fs_hz >= 42100 && fs_hz <= 46100)}, 64'd1);

    // Stop: drop enable at right-slot position 10, frame must still complete
    wait_frame_start(t0);
    bad = 1'b0;
    lr895 = 1'b0;
    bclk895 = 1'b0;
    for (int k = 1; k <= 996; k++) begin
      @(negedge clk_i);
      if (k == 590) enable_i = 1'b0;
      if (k == 895) begin
        lr895   = audio_lrclk_o;
        bclk895 = audio_bclk_o;
      end
      if (k >= 896 && (audio_bclk_o !== 1'b0 || audio_lrclk_o !== 1'b0 ||
                       audio_data_o !== 1'b0 || frame_start_o !== 1'b0)) bad = 1'b1;
    end
    check("stop_frame_runs_to_end", {62'b0, lr895, bclk895}, 64'd3);
    check("stop_idle_outputs", {63'b0, bad}, 64'd0);

    // Reset mid-frame with a pair waiting in the buffer
    push(24'h123456, 24'h654321);
    enable_i = 1'b1;
    wait_frame_start(t0);
    push(24'hABCDEF, 24'hFEDCBA);
    check("buffer_full_before_reset", {63'b0, s_ready_o}, 64'd0);
    repeat (300) @(negedge clk_i);
    rst_i = 1'b1;
    enable_i = 1'b0;
    @(negedge clk_i);
    check("midframe_reset_outputs",
          {58'b0, audio_bclk_o, audio_lrclk_o, audio_data_o, frame_start_o, underrun_o, s_ready_o},
          64'd1);
    check("midframe_reset_cnt", {48'b0, underrun_cnt_o}, 64'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    enable_i = 1'b1;
    wait_frame_start(t0);
    check("reset_discarded_buffer", {63'b0, underrun_o}, 64'd1);
    check("reset_cnt_restart", {48'b0, underrun_cnt_o}, 64'd1);
    enable_i = 1'b0;
    repeat (5) @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
